// File: rtl/f3_response_checker.sv
// f3_response_checker: scores observed samples of a 4-input boolean
// function against a 16-entry reference truth table. It tracks index
// coverage, counts mismatches with saturation and records the first
// failing index. It reports a verdict once all 16 indices have been seen.
//
// state | meaning
// IDLE  | no run since reset; waiting for start
// RUN   | accepting samples until every index has been covered
// DONE  | verdict valid; done/pass held until start or rst
module f3_response_checker #(
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      expected,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             f,
  output logic             in_ready,
  output logic [15:0]      covered,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [3:0]       first_err_idx,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      exp_q;
  logic [3:0]       idx;
  logic             accept;
  logic             mismatch;
  logic             complete;
  logic [15:0]      cov_nxt;
  logic [ERR_W-1:0] err_nxt;

  // Per-sample decode. A start in the same cycle wins, so that sample is dropped.
  always_comb begin
    idx      = {a, b, c, d};
    accept   = (state == RUN) && in_valid && !start;
    mismatch = accept && (f != exp_q[idx]);
    cov_nxt  = covered | (16'd1 << idx);
    err_nxt  = err_count;
    if (mismatch && (err_count != {ERR_W{1'b1}}))
      err_nxt = err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    complete = accept && (cov_nxt == 16'hFFFF);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. start restarts the run from any state.
  always_comb begin
    state_nxt = state;
    if (start)         state_nxt = RUN;
    else if (complete) state_nxt = DONE;
  end

  // Run bookkeeping. Every output is a flop that follows the state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q           <= '0;
      in_ready        <= 1'b0;
      covered         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (start) begin
      exp_q           <= expected;
      in_ready        <= 1'b1;
      covered         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (accept) begin
      covered   <= cov_nxt;
      err_count <= err_nxt;
      if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= idx;
      end
      if (complete) begin
        in_ready <= 1'b0;
        done     <= 1'b1;
        pass     <= (err_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_f3_response_checker.sv
// Directed bench for f3_response_checker: a vector table for single-cycle
// behaviour, followed by full-run sequences for the multi-cycle cases.
module tb_f3_response_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] expected = 16'h0;
  logic        in_valid = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, f = 1'b0;
  logic        in_ready;
  logic [15:0] covered;
  logic [4:0]  err_count;
  logic        first_err_valid;
  logic [3:0]  first_err_idx;
  logic        done;
  logic        pass;

  int checks = 0;
  int failures = 0;

  f3_response_checker #(.ERR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d), .f(f),
    .in_ready(in_ready), .covered(covered), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] exp;
    logic        vld;
    logic [3:0]  idx;
    logic        f;
    logic        e_rdy;
    logic [15:0] e_cov;
    logic [4:0]  e_err;
    logic        e_fev;
    logic [3:0]  e_fei;
    logic        e_done;
    logic        e_pass;
  } vec_t;

  vec_t vecs[12];

  // Reference function f = ab | cd with idx = {a,b,c,d}
  function automatic logic ref_f(input logic [3:0] i);
    return (i[3] & i[2]) | (i[1] & i[0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic [15:0] cov,
                         input logic [4:0] err, input logic fev, input logic [3:0] fei,
                         input logic dn, input logic ps);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".covered"}, 32'(covered), 32'(cov));
    chk({tag, ".err_count"}, 32'(err_count), 32'(err));
    chk({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(fev));
    chk({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(fei));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".pass"}, 32'(pass), 32'(ps));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] e);
    start = 1'b1; expected = e;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [3:0] i, input logic fv);
    in_valid = 1'b1; {a, b, c, d} = i; f = fv;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    //         rst   start  exp       vld   idx    f      rdy   cov       err    fev   fei    done  pass
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0,  1'b0, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd3,  1'b1,  1'b0, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'hF888, 1'b0, 4'd0,  1'b0,  1'b1, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd0,  1'b0,  1'b1, 16'h0001, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd5,  1'b1,  1'b1, 16'h0021, 5'd1, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd15, 1'b1,  1'b1, 16'h8021, 5'd1, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd3,  1'b0,  1'b1, 16'h8029, 5'd2, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'd9,  1'b1,  1'b1, 16'h8029, 5'd2, 1'b1, 4'd5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 4'd7,  1'b1,  1'b1, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 4'd7,  1'b1,  1'b1, 16'h0080, 5'd1, 1'b1, 4'd7, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd2,  1'b0,  1'b0, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd2,  1'b0,  1'b0, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};

    for (int v = 0; v < 12; v++) begin
      rst = vecs[v].rst; start = vecs[v].start; expected = vecs[v].exp;
      in_valid = vecs[v].vld; {a, b, c, d} = vecs[v].idx; f = vecs[v].f;
      tick();
      chk_all($sformatf("vec%0d", v), vecs[v].e_rdy, vecs[v].e_cov, vecs[v].e_err,
              vecs[v].e_fev, vecs[v].e_fei, vecs[v].e_done, vecs[v].e_pass);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    // Clean full run
    do_start(16'hF888);
    for (int i = 0; i < 16; i++) begin
      sample(4'(i), ref_f(4'(i)));
      if (i == 14) chk("clean.done_early", 32'(done), 32'd0);
    end
    chk_all("clean", 1'b0, 16'hFFFF, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1);
    // Samples while DONE are ignored
    sample(4'd0, 1'b1);
    chk_all("clean_ignored", 1'b0, 16'hFFFF, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1);

    // Run with errors at idx 5 and 9
    do_start(16'hF888);
    chk_all("restart_from_done", 1'b1, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      sample(4'(i), ref_f(4'(i)) ^ ((i == 5) || (i == 9)));
    chk_all("two_err", 1'b0, 16'hFFFF, 5'd2, 1'b1, 4'd5, 1'b1, 1'b0);

    // Gapped run with a duplicate mismatching idx 3 before completion
    do_start(16'hF888);
    expected = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      sample(4'(i), ref_f(4'(i)));
      tick();
    end
    sample(4'd3, 1'b0);
    tick();
    chk("gap.done_before_15", 32'(done), 32'd0);
    chk("gap.covered_before_15", 32'(covered), 32'h7FFF);
    sample(4'd15, 1'b1);
    chk_all("gap", 1'b0, 16'hFFFF, 5'd1, 1'b1, 4'd3, 1'b1, 1'b0);

    // Saturation
    do_start(16'hF888);
    for (int i = 0; i < 40; i++) sample(4'd0, 1'b1);
    chk("sat.err_mid", 32'(err_count), 32'd31);
    chk("sat.done_mid", 32'(done), 32'd0);
    for (int i = 1; i < 16; i++) sample(4'(i), ref_f(4'(i)));
    chk_all("sat", 1'b0, 16'hFFFF, 5'd31, 1'b1, 4'd0, 1'b1, 1'b0);

    // Reset out of DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_done", 1'b0, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
